// File: rtl/acc_cpu_ctrl_if.sv
// Instruction-memory bus and datapath control bundle of the accumulator-core sequencer.
// The sequencer is the master; the datapath, instruction memory and run source are the slave.
interface acc_cpu_ctrl_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic [7:0]       instr_data;
  logic [PC_W-1:0]  pc;
  logic [7:0]       ir;
  logic             acc_we;
  logic             acc_src_imm;
  logic [1:0]       alu_op;
  logic             reg_we;
  logic [3:0]       reg_sel;
  logic [3:0]       imm;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, instr_data,
    output pc, ir, acc_we, acc_src_imm, alu_op, reg_we, reg_sel, imm,
           busy, halted, illegal, retired
  );

  modport slave (
    output run, instr_data,
    input  pc, ir, acc_we, acc_src_imm, alu_op, reg_we, reg_sel, imm,
           busy, halted, illegal, retired
  );
endinterface

// File: rtl/acc_cpu_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator core (3 cycles per instruction).
// Optional macro ACC_CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt the core and set sticky illegal.
module acc_cpu_ctrl #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input logic            clk,
  input logic            rst_n,
  acc_cpu_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic [3:0]       opcode;
  logic             trap;

  assign opcode = ir_q[7:4];

`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  function automatic logic is_defined(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_MOV, OP_LDI, OP_HALT: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  assign trap = !is_defined(opcode);
`else
  // Undefined opcodes fall through EXECUTE with no strobes, i.e. as NOP.
  assign trap = 1'b0;
`endif

  // State and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RST;
      ir_q      <= 8'h00;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = bus.instr_data;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (trap) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (opcode == OP_HALT) begin
          // HALT never reaches EXECUTE, so it is retired on the way in.
          retired_d = retired_q + 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        retired_d = retired_q + 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control strobes, valid only while executing
  always_comb begin
    bus.acc_we      = 1'b0;
    bus.acc_src_imm = 1'b0;
    bus.alu_op      = ALU_PASS;
    bus.reg_we      = 1'b0;
    if (state_q == S_EXECUTE) begin
      case (opcode)
        OP_ADD: begin
          bus.acc_we = 1'b1;
          bus.alu_op = ALU_ADD;
        end
        OP_SUB: begin
          bus.acc_we = 1'b1;
          bus.alu_op = ALU_SUB;
        end
        OP_MOV: begin
          bus.reg_we = 1'b1;
        end
        OP_LDI: begin
          bus.acc_we      = 1'b1;
          bus.acc_src_imm = 1'b1;
        end
        default: begin
          bus.acc_we = 1'b0;
        end
      endcase
    end
  end

  assign bus.pc      = pc_q;
  assign bus.ir      = ir_q;
  assign bus.reg_sel = ir_q[3:0];
  assign bus.imm     = ir_q[3:0];
  assign bus.busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE);
  assign bus.halted  = (state_q == S_HALT);
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Scoreboard bench for acc_cpu_ctrl: expected strobes are queued per program and popped as they appear.
`timescale 1ns/1ps
module tb_acc_cpu_ctrl;
  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_cpu_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  acc_cpu_ctrl #(.PC_W(PC_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  assign bus.instr_data = mem[bus.pc];

  typedef struct packed {
    logic       acc_we;
    logic       src_imm;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [3:0] sel;
  } strobe_t;

  strobe_t exp_q[$];
  int      ret_q[$];
  int      n_cmp = 0;
  int      n_err = 0;

  function automatic strobe_t mk(input logic aw, input logic si, input logic [1:0] op,
                                 input logic rw, input logic [3:0] sel);
    strobe_t s;
    s.acc_we = aw; s.src_imm = si; s.alu_op = op; s.reg_we = rw; s.sel = sel;
    return s;
  endfunction

  // Reference decode written from the opcode table.
  function automatic strobe_t model(input logic [7:0] ins);
    strobe_t s;
    s = '0;
    s.sel = ins[3:0];
    case (ins[7:4])
      4'h1: begin s.acc_we = 1'b1; s.alu_op = 2'b01; end
      4'h2: begin s.acc_we = 1'b1; s.alu_op = 2'b10; end
      4'h5: s.reg_we = 1'b1;
      4'hD: begin s.acc_we = 1'b1; s.src_imm = 1'b1; end
      default: s = s;
    endcase
    return s;
  endfunction

  function automatic strobe_t obs();
    return mk(bus.acc_we, bus.acc_src_imm, bus.alu_op, bus.reg_we, bus.reg_sel);
  endfunction

  function automatic logic any_strobe();
    return bus.acc_we | bus.reg_we;
  endfunction

  task automatic do_reset();
    bus.run = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_prog(input logic [7:0] p [], input logic [7:0] fill);
    for (int a = 0; a < 256; a++) mem[a] = fill;
    for (int a = 0; a < p.size(); a++) mem[a] = p[a];
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.pc !== 8'd0) begin n_err++; $display("FAIL reset_pc: got %0d expected 0", bus.pc); end
    n_cmp++; if (bus.ir !== 8'h00) begin n_err++; $display("FAIL reset_ir: got %h expected 00", bus.ir); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.halted !== 1'b0) begin n_err++; $display("FAIL reset_busy_halted: got %b%b expected 00", bus.busy, bus.halted); end
    n_cmp++; if ({bus.acc_we, bus.acc_src_imm, bus.alu_op, bus.reg_we} !== 5'b0) begin n_err++; $display("FAIL reset_strobes: got %b expected 00000", {bus.acc_we, bus.acc_src_imm, bus.alu_op, bus.reg_we}); end
    n_cmp++; if (bus.retired !== 16'd0 || bus.illegal !== 1'b0) begin n_err++; $display("FAIL reset_retired_illegal: got %0d/%b expected 0/0", bus.retired, bus.illegal); end
  endtask

  task automatic test_program();
    logic [7:0] p [] = '{8'hD7, 8'h51, 8'hD9, 8'h11, 8'h00, 8'hF0};
    strobe_t e;
    int first = -1, last = -1;
    do_reset();
    load_prog(p, 8'h00);
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 1'b0, 4'h7));
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 1'b1, 4'h1));
    exp_q.push_back(mk(1'b1, 1'b1, 2'b00, 1'b0, 4'h9));
    exp_q.push_back(mk(1'b1, 1'b0, 2'b01, 1'b0, 4'h1));
    bus.run = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.acc_we && bus.reg_we) begin n_cmp++; n_err++; $display("FAIL prog_both_we: got 11 expected not both"); end
      if (any_strobe()) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL prog_extra_strobe: got %h expected none", obs()); end
        else begin
          e = exp_q.pop_front();
          if (obs() !== e || bus.imm !== e.sel) begin n_err++; $display("FAIL prog_strobe: got %h imm %h expected %h", obs(), bus.imm, e); end
        end
        n_cmp++;
        if (first < 0) begin
          first = i;
          if (i != 3) begin n_err++; $display("FAIL prog_first_latency: got %0d expected 3", i); end
        end else if (i - last != 3) begin
          n_err++; $display("FAIL prog_spacing: got %0d expected 3", i - last);
        end
        last = i;
      end
      if (bus.halted) break;
    end
    n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL prog_halt_timeout: got %b expected 1", bus.halted); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL prog_missing_strobes: got %0d left expected 0", exp_q.size()); end
    n_cmp++; if (bus.pc !== 8'd6) begin n_err++; $display("FAIL prog_pc: got %0d expected 6", bus.pc); end
    n_cmp++; if (bus.retired !== 16'd6) begin n_err++; $display("FAIL prog_retired: got %0d expected 6", bus.retired); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.illegal !== 1'b0) begin n_err++; $display("FAIL prog_busy_illegal: got %b/%b expected 0/0", bus.busy, bus.illegal); end
  endtask

  task automatic test_halt_hold();
    logic [7:0] pc0;
    logic [15:0] r0;
    pc0 = bus.pc;
    r0 = bus.retired;
    for (int i = 0; i < 10; i++) begin
      bus.run = ~bus.run;
      @(negedge clk);
      n_cmp++;
      if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.pc !== pc0 || bus.retired !== r0 || any_strobe() !== 1'b0) begin
        n_err++;
        $display("FAIL halt_hold: got h%b b%b pc%0d r%0d s%b expected h1 b0 pc%0d r%0d s0", bus.halted, bus.busy, bus.pc, bus.retired, any_strobe(), pc0, r0);
      end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_nop_wrap();
    logic [7:0] p [] = '{8'h00};
    logic [7:0] prev_pc;
    logic [15:0] prev_ret;
    int wrapped = 0, bad = 0;
    do_reset();
    load_prog(p, 8'h00);
    ret_q.delete();
    for (int k = 1; k <= 260; k++) ret_q.push_back(k);
    prev_pc = bus.pc;
    prev_ret = bus.retired;
    bus.run = 1'b1;
    for (int i = 1; i <= 781; i++) begin
      @(negedge clk);
      if (prev_pc == 8'd255 && bus.pc == 8'd0) wrapped++;
      if (bus.retired !== prev_ret) begin
        n_cmp++;
        if (ret_q.size() == 0) begin n_err++; $display("FAIL nop_retired_extra: got %0d expected none", bus.retired); end
        else if (bus.retired !== 16'(ret_q.pop_front())) begin n_err++; $display("FAIL nop_retired_step: got %0d expected %0d", bus.retired, prev_ret + 16'd1); end
      end
      if (any_strobe() || bus.halted) bad++;
      prev_pc = bus.pc;
      prev_ret = bus.retired;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL nop_strobe_or_halt: got %0d cycles expected 0", bad); end
    n_cmp++; if (wrapped != 1) begin n_err++; $display("FAIL nop_pc_wrap: got %0d wraps expected 1", wrapped); end
    n_cmp++; if (bus.retired !== 16'd260) begin n_err++; $display("FAIL nop_retired: got %0d expected 260", bus.retired); end
    n_cmp++; if (bus.pc !== 8'd4) begin n_err++; $display("FAIL nop_pc: got %0d expected 4", bus.pc); end
    bus.run = 1'b0;
  endtask

  task automatic test_illegal();
    logic [7:0] p [] = '{8'h3A, 8'hF0};
    int strobes = 0, ill_seen = 0;
    do_reset();
    load_prog(p, 8'h00);
    bus.run = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (any_strobe()) strobes++;
      if (bus.illegal) ill_seen++;
      if (bus.halted) break;
    end
    n_cmp++; if (bus.halted !== 1'b1) begin n_err++; $display("FAIL illegal_halt: got %b expected 1", bus.halted); end
    n_cmp++; if (strobes != 0) begin n_err++; $display("FAIL illegal_strobes: got %0d expected 0", strobes); end
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
    n_cmp++; if (bus.illegal !== 1'b1) begin n_err++; $display("FAIL illegal_flag: got %b expected 1", bus.illegal); end
    n_cmp++; if (bus.retired !== 16'd0) begin n_err++; $display("FAIL illegal_retired: got %0d expected 0", bus.retired); end
    n_cmp++; if (bus.pc !== 8'd1) begin n_err++; $display("FAIL illegal_pc: got %0d expected 1", bus.pc); end
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.illegal !== 1'b1) begin n_err++; $display("FAIL illegal_sticky: got %b expected 1", bus.illegal); end
`else
    n_cmp++; if (ill_seen != 0 || bus.illegal !== 1'b0) begin n_err++; $display("FAIL illegal_flag: got %0d/%b expected 0/0", ill_seen, bus.illegal); end
    n_cmp++; if (bus.retired !== 16'd2) begin n_err++; $display("FAIL illegal_retired: got %0d expected 2", bus.retired); end
    n_cmp++; if (bus.pc !== 8'd2) begin n_err++; $display("FAIL illegal_pc: got %0d expected 2", bus.pc); end
`endif
    bus.run = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] p [] = '{8'hD7, 8'h51, 8'hD9, 8'h11, 8'h00, 8'hF0};
    int found = 0;
    do_reset();
    load_prog(p, 8'h00);
    bus.run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.acc_we && bus.alu_op == 2'b01) begin found = 1; break; end
    end
    n_cmp++; if (found != 1) begin n_err++; $display("FAIL mid_add_timeout: got %0d expected 1", found); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.pc !== 8'd0 || bus.ir !== 8'h00 || bus.retired !== 16'd0) begin n_err++; $display("FAIL mid_async_regs: got pc%0d ir%h r%0d expected 0 00 0", bus.pc, bus.ir, bus.retired); end
    n_cmp++; if ({bus.acc_we, bus.acc_src_imm, bus.alu_op, bus.reg_we, bus.busy, bus.halted} !== 7'b0) begin n_err++; $display("FAIL mid_async_ctrl: got %b expected 0000000", {bus.acc_we, bus.acc_src_imm, bus.alu_op, bus.reg_we, bus.busy, bus.halted}); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int a = 0; a < 4; a++) exp_q.push_back(model(p[a]));
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_cmp++; if (bus.pc !== 8'd0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_restart_pc: got pc%0d busy%b expected pc0 busy1", bus.pc, bus.busy); end
      end
      if (any_strobe()) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL mid_extra_strobe: got %h expected none", obs()); end
        else if (obs() !== exp_q[0]) begin n_err++; $display("FAIL mid_strobe: got %h expected %h", obs(), exp_q.pop_front()); end
        else void'(exp_q.pop_front());
      end
      if (bus.halted) break;
    end
    n_cmp++; if (bus.halted !== 1'b1 || bus.retired !== 16'd6 || exp_q.size() != 0) begin n_err++; $display("FAIL mid_rerun: got h%b r%0d left%0d expected h1 r6 left0", bus.halted, bus.retired, exp_q.size()); end
    bus.run = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] p [] = '{8'h23, 8'h5A, 8'hDF, 8'h10, 8'h2F, 8'hF0};
    strobe_t e;
    do_reset();
    load_prog(p, 8'h00);
    exp_q.delete();
    for (int a = 0; a < 5; a++) exp_q.push_back(model(p[a]));
    bus.run = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (any_strobe()) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra_strobe: got %h expected none", obs()); end
        else begin
          e = exp_q.pop_front();
          if (obs() !== e || bus.imm !== e.sel) begin n_err++; $display("FAIL b2b_strobe: got %h imm %h expected %h", obs(), bus.imm, e); end
        end
      end
      if (bus.halted) break;
    end
    n_cmp++; if (bus.halted !== 1'b1 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_halt: got h%b left%0d expected h1 left0", bus.halted, exp_q.size()); end
    n_cmp++; if (bus.retired !== 16'd6 || bus.pc !== 8'd6) begin n_err++; $display("FAIL b2b_counts: got r%0d pc%0d expected r6 pc6", bus.retired, bus.pc); end
    bus.run = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    test_reset();
    test_program();
    test_halt_hold();
    test_nop_wrap();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/acc_cpu_ctrl.md
Name: acc_cpu_ctrl

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator core. Owns the program counter and instruction register and drives the instruction-memory address. Decodes 8-bit instructions (opcode[7:4], operand[3:0]) into one-cycle control strobes for the accumulator, register-file and ALU datapath. Stops on HALT.

Parameters:
PC_W, 8, program counter / instruction-memory address width
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; leaves IDLE when high
instr_data  in  8  instruction memory read data (combinational from pc)
pc  out  PC_W  instruction memory address
ir  out  8  latched instruction register
acc_we  out  1  accumulator write strobe
acc_src_imm  out  1  1: ACC <= imm; 0: ACC <= ALU result
alu_op  out  2  00 pass, 01 add, 10 sub, 11 reserved
reg_we  out  1  register-file write strobe (Rn <= ACC)
reg_sel  out  4  register index (ir[3:0])
imm  out  4  immediate (ir[3:0])
busy  out  1  high in FETCH/DECODE/EXECUTE
halted  out  1  high in HALT
illegal  out  1  sticky illegal-opcode flag
retired  out  CNT_W  count of executed instructions

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=8'h00, retired=0, illegal=0. All strobes, busy and halted are 0.
- States: IDLE, FETCH, DECODE, EXECUTE, HALT. Encoding is free.
- IDLE: run=1 -> FETCH next edge; else stay. run is sampled only in IDLE.
- FETCH (1 cycle): pc presented. At edge: ir <= instr_data, pc <= pc+1 modulo 2^PC_W (255 wraps to 0), -> DECODE.
- DECODE (1 cycle): no strobes. -> EXECUTE, except opcode F -> HALT.
- EXECUTE (1 cycle): strobes are combinational from state==EXECUTE and ir, and are high for exactly this cycle. retired increments (wraps) at the edge. -> FETCH.
- Opcodes:
  - 0 NOP: no strobes.
  - 1 ADD: acc_we=1, alu_op=01, acc_src_imm=0.
  - 2 SUB: acc_we=1, alu_op=10.
  - 5 MOV: reg_we=1.
  - D LDI: acc_we=1, acc_src_imm=1.
  - F HALT: does not reach EXECUTE. Counted in retired on entry to HALT.
  - Others: see optional feature.
- reg_sel and imm always equal ir[3:0]. Strobes outside EXECUTE are 0.
- Throughput: 3 cycles per instruction. First strobe appears 3 cycles after the IDLE->FETCH edge.
- HALT: halted=1, busy=0. pc holds the address after the HALT. Stays until reset; run is ignored.
- acc_we and reg_we are never both 1.
- Reset asserted mid-instruction: immediate return to reset state. A partial EXECUTE strobe is permitted only combinationally before the reset takes effect.

Optional Feature:
ACC_CTRL_ILLEGAL_TRAP_EN
- Defined: an undefined opcode at DECODE -> HALT with illegal=1 (sticky until reset). The instruction is not counted in retired.
- Undefined: undefined opcodes execute as NOP (counted). illegal is tied 0.

Test Plan:
- Reset then run=0 for 5 cycles -> state IDLE, pc=0, busy=0, all strobes 0, retired=0.
- Program D7,51,D9,11,00,F0 at 0..5, run=1 -> EXECUTE strobes in this order, each 3 cycles apart:
  - LDI imm=7
  - MOV reg_sel=1
  - LDI imm=9
  - ADD alu_op=01 reg_sel=1
  - none (NOP)
  Then halted=1, pc=6, retired=6, busy=0.
- Fill all 256 words with NOP, run -> pc wraps 255->0, retired increments each instruction, no strobes, never halts.
- Instruction 8'h3A at addr 0 -> with ACC_CTRL_ILLEGAL_TRAP_EN: HALT, illegal=1, retired=0. Without it: NOP, retired=1, illegal=0.
- rst_n pulsed low during EXECUTE of the ADD -> outputs return to reset values asynchronously. A re-run restarts from pc=0.
- In HALT, toggle run for 10 cycles -> remains halted, pc stable, no strobes.
